// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM arbiter: RAM geometry, statistics counter
// width, FSM state encoding and operation encoding.
package ram_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int STAT_W = 16;

    // Arbiter FSM states, kept as plain 2-bit constants so the encoding is
    // visible on the debug port and easy to match in checkers.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester at or
// after the pointer, searching upward with wrap-around.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_idx;

    // Scan requesters in rotation order starting at the pointer; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!o_any && i_valid[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port RAM (combinational level-sensitive
// write, registered read) between NUM_REQ requesters. Each accepted request
// walks IDLE -> ACCESS -> EXEC -> RESP; the write strobe is only raised in
// EXEC so address/data are always settled a full cycle before and after it.
// Handshake: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; ready is only ever offered in IDLE, to the single
// round-robin winner, and the requester keeps its request fields stable until
// then. Completion is a one-cycle rsp_valid[i] pulse with no back-pressure.
// Optional feature macro: RAM_ARB_STATS_EN adds grant_count, one saturating
// 16-bit accept counter per requester.
module ram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ram_arb_pkg::ADDR_W,
    parameter int DATA_W  = ram_arb_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        ram_write,
    output logic [ADDR_W-1:0]           ram_adress,
    output logic [DATA_W-1:0]           ram_in,
    input  logic [DATA_W-1:0]           ram_out,
    output logic [1:0]                  dbg_state
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*ram_arb_pkg::STAT_W-1:0] grant_count
`endif
);

    import ram_arb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_id;
    logic               r_op;
    logic [ADDR_W-1:0]  r_adress;
    logic [DATA_W-1:0]  r_in;
    logic               r_ram_write;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic [NUM_REQ-1:0] w_grant;
    logic [PW-1:0]      w_idx;
    logic               w_any;
    logic               w_fire;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Ready is offered only in IDLE, and only to the current winner.
    always_comb begin
        req_ready = (r_state == ST_IDLE) ? w_grant : '0;
        w_fire    = (r_state == ST_IDLE) && w_any;
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign ram_write  = r_ram_write;
    assign ram_adress = r_adress;
    assign ram_in     = r_in;
    assign dbg_state  = r_state;

    // Main sequencer: latch the accepted request, strobe or read the RAM, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_op        <= OP_READ;
            r_adress    <= '0;
            r_in        <= '0;
            r_ram_write <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_id     <= w_idx;
                        r_op     <= req_write[w_idx];
                        r_adress <= req_addr[w_idx*ADDR_W +: ADDR_W];
                        r_in     <= req_wdata[w_idx*DATA_W +: DATA_W];
                        r_ptr    <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Setup cycle done; raise the strobe for exactly the EXEC cycle.
                    r_ram_write <= (r_op == OP_WRITE);
                    r_state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_ram_write <= 1'b0;
                    if (r_op == OP_READ) begin
                        r_rsp_rdata <= ram_out;
                    end
                    r_rsp_valid <= NUM_REQ'(1) << r_id;
                    r_state     <= ST_RESP;
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] r_grant_count;

    // Per-requester accept counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_fire && w_grant[i] && (r_grant_count[i*STAT_W +: STAT_W] != '1)) begin
                    r_grant_count[i*STAT_W +: STAT_W] <= r_grant_count[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign grant_count = r_grant_count;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model, a transaction-level reference model
// checked against the DUT every cycle, and directed scenarios with literal
// expectations.
module tb_ram_arbiter;

    localparam int N  = 2;
    localparam int AW = 7;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_write;
    logic [AW-1:0]   ram_adress;
    logic [DW-1:0]   ram_in;
    logic [DW-1:0]   ram_out = '0;
    logic [1:0]      dbg_state;
`ifdef RAM_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_write  (ram_write),
        .ram_adress (ram_adress),
        .ram_in     (ram_in),
        .ram_out    (ram_out),
        .dbg_state  (dbg_state)
`ifdef RAM_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    // RAM model: write while strobe is high, registered read.
    logic [DW-1:0] ram_mem [0:127];
    initial for (int i = 0; i < 128; i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_adress] <= ram_in;
        ram_out <= ram_mem[ram_adress];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    bit            m_init  = 0;
    int            m_phase = 0;   // cycles elapsed since accept, 0 = idle
    int            m_ptr   = 0;
    int            m_id    = 0;
    bit            m_op    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_mem [0:127];
    int            grant_log[$];
    int            acc_cyc[$];
    initial for (int i = 0; i < 128; i++) m_mem[i] = '0;

    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        cyc++;
        if (rst) begin
            if (m_phase == 2 && m_op) m_mem[m_addr] = m_data;
            m_init = 1; m_phase = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_rdata = '0;
        end else if (m_init) begin
            case (m_phase)
                0: begin
                    w = model_winner(req_valid, m_ptr);
                    if (w >= 0) begin
                        m_id = w; m_op = req_write[w];
                        m_addr = req_addr[w*AW +: AW]; m_data = req_wdata[w*DW +: DW];
                        m_ptr = (w + 1) % N; m_phase = 1;
                        grant_log.push_back(w); acc_cyc.push_back(cyc);
                    end
                end
                1: m_phase = 2;
                2: begin
                    if (m_op) m_mem[m_addr] = m_data;
                    else      m_rdata = m_mem[m_addr];
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, plus simple event counters.
    int            wr_pulses  = 0;
    int            rsp_pulses = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    always @(negedge clk) begin
        int w;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        if (m_init) begin
            w = model_winner(req_valid, m_ptr);
            e_ready = (m_phase == 0 && w >= 0) ? N'(1) << w : '0;
            e_rsp   = (m_phase == 3) ? N'(1) << m_id : '0;
            chk("req_ready",  req_ready,  e_ready);
            chk("ram_write",  ram_write,  (m_phase == 2) && m_op);
            chk("ram_adress", ram_adress, m_addr);
            chk("ram_in",     ram_in,     m_data);
            chk("rsp_valid",  rsp_valid,  e_rsp);
            chk("rsp_rdata",  rsp_rdata,  m_rdata);
            chk("state",      dbg_state,  m_phase);
            if (ram_write) begin
                wr_pulses++; last_wr_addr = ram_adress; last_wr_data = ram_in;
            end
            if (rsp_valid != '0) rsp_pulses++;
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic txn(input int id, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
        bit got;
        rd = 'x; lat = -1;
        req_valid[id] = 1'b1; req_write[id] = wr;
        req_addr[id*AW +: AW] = a; req_wdata[id*DW +: DW] = d;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (!got) return;
        got = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin got = 1; lat = i; rd = rsp_rdata; end
        end
        if (!got) chk("rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        int lat, p0, ok;
        bit got;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ram_write", ram_write, 0);
        chk("reset_ram_adress", ram_adress, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;

        // Write 5 to 24 from requester 0.
        p0 = wr_pulses;
        txn(0, 1, 7'd24, 32'd5, rd, lat);
        chk("wr24_latency", lat, 3);
        chk("wr24_pulses", wr_pulses - p0, 1);
        chk("wr24_strobe_addr", last_wr_addr, 24);
        chk("wr24_strobe_data", last_wr_data, 5);

        // Read back from requester 1.
        p0 = wr_pulses;
        txn(1, 0, 7'd24, 32'd0, rd, lat);
        chk("rd24_latency", lat, 3);
        chk("rd24_data", rd, 5);
        chk("rd24_no_write", wr_pulses - p0, 0);

        // Both requesting continuously: strict alternation, one accept per 4 cycles.
        grant_log.delete(); acc_cyc.delete();
        req_write = 2'b11;
        req_addr  = {7'd11, 7'd10};
        req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        req_valid = 2'b11;
        repeat (16) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk); #1;
        chk("rr_accepts", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("rr_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}, 16'h0101);
            chk("rr_spacing", {acc_cyc[1]-acc_cyc[0], acc_cyc[2]-acc_cyc[1], acc_cyc[3]-acc_cyc[2]}, {32'd4, 32'd4, 32'd4});
        end
        txn(0, 0, 7'd11, 32'd0, rd, lat);
        chk("rd11_data", rd, 32'hBBBB_0001);

        // Reset during EXEC of a write: no response, but the write lands.
        req_valid[1] = 1'b1; req_write[1] = 1'b1;
        req_addr[AW +: AW] = 7'd1; req_wdata[DW +: DW] = 32'd12;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1;
        end
        if (!got) chk("rst_accept_timeout", 0, 1);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        p0 = rsp_pulses;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_ram_write", ram_write, 0);
        chk("midrst_ram_adress", ram_adress, 0);
        chk("midrst_ram_in", ram_in, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_rdata", rsp_rdata, 0);
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", rsp_pulses - p0, 0);
        @(posedge clk); #1;
        txn(0, 0, 7'd1, 32'd0, rd, lat);
        chk("midrst_write_landed", rd, 12);

        // Top address boundary and an untouched address.
        txn(0, 1, 7'd127, 32'hFFFF_FFFF, rd, lat);
        txn(0, 0, 7'd127, 32'd0, rd, lat);
        chk("rd127_data", rd, 32'hFFFF_FFFF);
        txn(1, 0, 7'd0, 32'd0, rd, lat);
        chk("rd0_untouched", rd, 0);

`ifdef RAM_ARB_STATS_EN
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("stats_after_rst", grant_count, 0);
        for (int i = 0; i < 3; i++) txn(0, 0, 7'd2, 32'd0, rd, lat);
        for (int i = 0; i < 2; i++) txn(1, 0, 7'd3, 32'd0, rd, lat);
        chk("stats_counts", grant_count, {16'd2, 16'd3});
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("stats_cleared", grant_count, 0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
